// File: rtl/serial_io_ctrl_pkg.sv
// Shared definitions for the serial I/O controller: TX FSM states,
// error-flag bit positions and the count-width helper.
package serial_io_ctrl_pkg;

   localparam int DATA_W       = 8;
   localparam int ERR_RX_UNDER = 0;
   localparam int ERR_TX_OVER  = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_t;

   // Occupancy counters need one extra bit so that "full" (count == depth) is representable.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/serial_io_ctrl_byte_fifo.sv
// 8-bit synchronous FIFO with occupancy count and a head-of-queue output.
// Pushes into a full FIFO and pops from an empty one are silently ignored;
// the caller decides whether that is an error.
module serial_io_ctrl_byte_fifo
   import serial_io_ctrl_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int CW    = count_width(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   localparam int PW = CW - 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;
   logic              do_push;
   logic              do_pop;

   // Status decodes registered state only, so no input reaches these outputs combinationally.
   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, so block order never matters.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage write port.
   always_ff @(posedge clock) begin
      // NOTE: the data array is deliberately not reset; empty/count guard every read, so stale contents are never visible.
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/serial_io_ctrl.sv
// Serial port sequencer: RX FIFO towards the CPU, TX FIFO from the CPU,
// and a paced valid/ready transmit FSM draining the TX FIFO to the link.
module serial_io_ctrl
   import serial_io_ctrl_pkg::*;
#(
   parameter  int DEPTH      = 8,
   parameter  int GAP_CYCLES = 0,
   localparam int CW         = count_width(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_valid,
   input  logic              cpu_rden,
   output logic              cpu_ready,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_wren,
   input  logic [DATA_W-1:0] ext_rx_data,
   input  logic              ext_rx_valid,
   output logic              ext_rx_ready,
   output logic [DATA_W-1:0] ext_tx_data,
   output logic              ext_tx_valid,
   input  logic              ext_tx_ready,
   output logic [CW-1:0]     rx_count,
   output logic [CW-1:0]     tx_count,
   output logic [1:0]        err_flags,
   input  logic              err_clr,
   output logic              tx_busy
);

   localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]   GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   logic              rx_full;
   logic              rx_empty;
   logic              tx_full;
   logic              tx_empty;
   logic [DATA_W-1:0] tx_head;
   logic              tx_pop;
   logic [1:0]        err_new;

   tx_state_t         state;
   tx_state_t         state_nx;
   logic [DATA_W-1:0] data_nx;
   logic              valid_nx;
   logic [GW-1:0]     gap_cnt;
   logic [GW-1:0]     gap_nx;

   serial_io_ctrl_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (ext_rx_valid),
      .push_data (ext_rx_data),
      .pop       (cpu_rden),
      .head      (cpu_rdata),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   serial_io_ctrl_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cpu_wren),
      .push_data (cpu_wdata),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   assign cpu_valid    = ~rx_empty;
   assign ext_rx_ready = ~rx_full;
   assign cpu_ready    = ~tx_full;
   assign tx_busy      = (state != ST_IDLE);

   assign err_new[ERR_RX_UNDER] = cpu_rden & rx_empty;
   assign err_new[ERR_TX_OVER]  = cpu_wren & tx_full;

   // TX FSM next-state and output logic.
   always_comb begin
      // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
      state_nx = state;
      data_nx  = ext_tx_data;
      valid_nx = ext_tx_valid;
      gap_nx   = gap_cnt;
      tx_pop   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!tx_empty) begin
               tx_pop   = 1'b1;
               data_nx  = tx_head;
               valid_nx = 1'b1;
               state_nx = ST_SEND;
            end
         end
         ST_SEND: begin
            if (ext_tx_ready) begin
               if (GAP_CYCLES > 0) begin
                  valid_nx = 1'b0;
                  gap_nx   = GAP_LOAD;
                  state_nx = ST_GAP;
               end else if (!tx_empty) begin
                  // Back-to-back: next byte replaces the accepted one, valid stays high.
                  tx_pop  = 1'b1;
                  data_nx = tx_head;
               end else begin
                  valid_nx = 1'b0;
                  state_nx = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == '0) state_nx = ST_IDLE;
            else               gap_nx   = gap_cnt - GW'(1);
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // TX FSM state, registered link outputs and gap counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         ext_tx_data  <= '0;
         ext_tx_valid <= 1'b0;
         gap_cnt      <= '0;
      end else begin
         state        <= state_nx;
         ext_tx_data  <= data_nx;
         ext_tx_valid <= valid_nx;
         gap_cnt      <= gap_nx;
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) err_flags <= '0;
      else       err_flags <= (err_clr ? 2'b00 : err_flags) | err_new;
   end

endmodule
